hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 121 ++++++++++++
 tb/tb_hazard_control_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls and control-transfer flushes,
// with saturating statistics counters for stall cycles and flush events.
module hazard_control_unit #(
   parameter int unsigned     REG_W     = 3,
   parameter int unsigned     OP_W      = 5,
   parameter int unsigned     LOAD_LAT  = 1,
   parameter int unsigned     FLUSH_CYC = 1,
   parameter logic [OP_W-1:0] JMP_OP0   = 5'b11100,
   parameter logic [OP_W-1:0] JMP_OP1   = 5'b11101,
   parameter logic [OP_W-1:0] JMP_OP2   = 5'b11110,
   parameter bit              IGNORE_R0 = 1'b1,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_exe_memrd,
   input  logic [REG_W-1:0] id_exe_rd,
   input  logic [REG_W-1:0] if_id_rs,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic [OP_W-1:0]  opcode,
   input  logic             branch_taken,
   output logic             if_id_wr,
   output logic             pc_wr,
   output logic             id_exe_zero,
   output logic             flush,
   output logic             busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       hazard;
   logic       ctrl;

   // Hazard and control-transfer detection from the current pipeline contents
   always_comb begin
      hazard = id_exe_memrd &&
               ((id_exe_rd == if_id_rs) || (id_exe_rd == if_id_rt)) &&
               !(IGNORE_R0 && (id_exe_rd == '0));
      ctrl   = branch_taken ||
               (opcode == JMP_OP0) || (opcode == JMP_OP1) || (opcode == JMP_OP2);
   end

   // Pipeline control outputs, decoded from state and live inputs
   always_comb begin
      if_id_wr    = 1'b1;
      pc_wr       = 1'b1;
      id_exe_zero = 1'b0;
      flush       = 1'b0;
      busy        = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (ctrl) begin
                  flush       = 1'b1;
                  id_exe_zero = 1'b1;
               end else if (hazard) begin
                  if_id_wr    = 1'b0;
                  pc_wr       = 1'b0;
                  id_exe_zero = 1'b1;
               end
            end
            STALL: begin
               if_id_wr    = 1'b0;
               pc_wr       = 1'b0;
               id_exe_zero = 1'b1;
               busy        = 1'b1;
            end
            FLUSH: begin
               flush       = 1'b1;
               id_exe_zero = 1'b1;
               busy        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State sequencing, hold counter and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl) begin
                  if (FLUSH_CYC > 1) begin
                     state <= FLUSH;
                     cnt   <= 4'(FLUSH_CYC - 1);
                  end
               end else if (hazard) begin
                  if (LOAD_LAT > 1) begin
                     state <= STALL;
                     cnt   <= 4'(LOAD_LAT - 1);
                  end
               end
            end
            STALL, FLUSH: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase

         if (!pc_wr && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if ((state == IDLE) && ctrl && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized bench for hazard_control_unit: three parameterizations share one
// stimulus stream and are each checked against a cycle-level reference model.
module tb_hazard_control_unit;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       memrd;
   logic [2:0] rd, rs, rt;
   logic [4:0] op;
   logic       bt;

   logic [4:0]  ctl [NI];
   logic [15:0] scnt [NI];
   logic [15:0] fcnt [NI];

   logic w0, p0, z0, f0, b0;
   logic w1, p1, z1, f1, b1;
   logic w2, p2, z2, f2, b2;
   logic [15:0] s0, c0, s1, c1;
   logic [1:0]  s2, c2;

   // Per-instance configuration, mirrored from the instance overrides below
   int lat [NI] = '{1, 3, 4};
   int fcy [NI] = '{1, 2, 3};
   bit ign [NI] = '{1'b1, 1'b0, 1'b1};
   int cmax[NI] = '{65535, 65535, 3};

   // Reference model state
   int rem   [NI];
   int m_sc  [NI];
   int m_fc  [NI];
   bit e_pcw [NI];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   hazard_control_unit u0 (
      .clk(clk), .rst(rst), .id_exe_memrd(memrd), .id_exe_rd(rd),
      .if_id_rs(rs), .if_id_rt(rt), .opcode(op), .branch_taken(bt),
      .if_id_wr(w0), .pc_wr(p0), .id_exe_zero(z0), .flush(f0), .busy(b0),
      .stall_count(s0), .flush_count(c0));

   hazard_control_unit #(.LOAD_LAT(3), .FLUSH_CYC(2), .IGNORE_R0(1'b0)) u1 (
      .clk(clk), .rst(rst), .id_exe_memrd(memrd), .id_exe_rd(rd),
      .if_id_rs(rs), .if_id_rt(rt), .opcode(op), .branch_taken(bt),
      .if_id_wr(w1), .pc_wr(p1), .id_exe_zero(z1), .flush(f1), .busy(b1),
      .stall_count(s1), .flush_count(c1));

   hazard_control_unit #(.LOAD_LAT(4), .FLUSH_CYC(3), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .id_exe_memrd(memrd), .id_exe_rd(rd),
      .if_id_rs(rs), .if_id_rt(rt), .opcode(op), .branch_taken(bt),
      .if_id_wr(w2), .pc_wr(p2), .id_exe_zero(z2), .flush(f2), .busy(b2),
      .stall_count(s2), .flush_count(c2));

   assign ctl[0] = {w0, p0, z0, f0, b0};
   assign ctl[1] = {w1, p1, z1, f1, b1};
   assign ctl[2] = {w2, p2, z2, f2, b2};
   assign scnt[0] = s0;
   assign scnt[1] = s1;
   assign scnt[2] = {14'd0, s2};
   assign fcnt[0] = c0;
   assign fcnt[1] = c1;
   assign fcnt[2] = {14'd0, c2};

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive, check outputs against the model, then advance the model
   task automatic step(input bit r, input bit m, input int d, input int s,
                       input int t, input int o, input bit b);
      bit haz, ctr;
      int exp_ctl;
      @(negedge clk);
      rst = r; memrd = m; rd = 3'(d); rs = 3'(s); rt = 3'(t); op = 5'(o); bt = b;
      #1;
      ctr = b || (o == 28) || (o == 29) || (o == 30);
      for (int k = 0; k < NI; k++) begin
         haz = m && ((d == s) || (d == t)) && !(ign[k] && d == 0);
         // packed as {if_id_wr, pc_wr, id_exe_zero, flush, busy}
         if (r)                      exp_ctl = 5'b11000;
         else if (rem[k] < 0)        exp_ctl = 5'b11111;   // flush hold
         else if (rem[k] > 0)        exp_ctl = 5'b00101;   // stall hold
         else if (ctr)               exp_ctl = 5'b11110;
         else if (haz)               exp_ctl = 5'b00100;
         else                        exp_ctl = 5'b11000;
         e_pcw[k] = exp_ctl[3];
         check($sformatf("u%0d ctl", k), int'(ctl[k]), exp_ctl);
         check($sformatf("u%0d stall_count", k), int'(scnt[k]), m_sc[k]);
         check($sformatf("u%0d flush_count", k), int'(fcnt[k]), m_fc[k]);
      end
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         haz = m && ((d == s) || (d == t)) && !(ign[k] && d == 0);
         if (r) begin
            rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
         end else begin
            if (!e_pcw[k] && m_sc[k] < cmax[k]) m_sc[k]++;
            // rem > 0: stall cycles left; rem < 0: flush cycles left (negated)
            if (rem[k] > 0)      rem[k]--;
            else if (rem[k] < 0) rem[k]++;
            else if (ctr) begin
               if (m_fc[k] < cmax[k]) m_fc[k]++;
               rem[k] = -(fcy[k] - 1);
            end else if (haz)    rem[k] = lat[k] - 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 2, 0, 0);
   endtask

   initial begin
      rst = 1'b1; memrd = 1'b0; rd = '0; rs = '0; rt = '0; op = '0; bt = 1'b0;
      for (int k = 0; k < NI; k++) begin
         rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0; e_pcw[k] = 1'b1;
      end
      repeat (2) @(posedge clk);

      step(1, 0, 0, 0, 0, 0, 0);             // reset outputs
      step(0, 1, 3, 3, 5, 0, 0);             // single load-use hazard
      idle(5);
      step(0, 1, 3, 3, 0, 5'b11101, 0);      // jump beats hazard
      idle(4);
      step(0, 1, 0, 0, 0, 0, 0);             // r0 hazard: only u1 stalls
      idle(5);
      step(0, 1, 3, 3, 0, 0, 0);             // hazard, then branch during stall
      step(0, 0, 0, 1, 2, 0, 1);
      idle(4);
      step(0, 1, 4, 1, 4, 0, 0);             // reset in the middle of a stall
      step(0, 0, 0, 1, 2, 0, 0);
      step(1, 0, 0, 1, 2, 0, 0);
      idle(2);
      for (int i = 0; i < 6; i++) begin      // repeated hazards saturate u2
         step(0, 1, 2, 5, 2, 0, 0);
         idle(4);
      end

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 31), $urandom_range(0, 9) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
